// File: rtl/perceptron_trainer.sv
// Single-layer perceptron over a 4-bit binary feature vector with on-line training.
// Forward pass is one weight per cycle; a misclassified sample triggers a saturating update.
module perceptron_trainer #(
  parameter int DATA_W     = 8,
  parameter int LR         = 1,
  parameter int CONV_COUNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        sample_x,
  input  logic              sample_t,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              result_valid,
  output logic              y_out,
  output logic              err_out,
  output logic              converged
);

  localparam int ACC_W = DATA_W + 3;
  localparam int CNT_W = $clog2(CONV_COUNT + 1);
  localparam logic signed [DATA_W+1:0] SAT_MAX = (DATA_W+2)'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W+1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [DATA_W+1:0] LR_EXT  = (DATA_W+2)'(LR);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, ACC3, DECIDE, UPDATE, DONE} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  w [4];
  logic signed [DATA_W-1:0]  bias;
  logic signed [ACC_W-1:0]   acc;
  logic [3:0]                x_r;
  logic                      t_r;
  logic                      y_r;
  logic [CNT_W-1:0]          cnt;
  logic [1:0]                acc_idx;
  logic                      y_dec, err_dec;

  // Two guard bits make the +/-LR step exact before clamping.
  function automatic logic signed [DATA_W-1:0] step_sat(input logic signed [DATA_W-1:0] v,
                                                        input logic up);
    logic signed [DATA_W+1:0] s;
    s = {{2{v[DATA_W-1]}}, v};
    s = up ? s + LR_EXT : s - LR_EXT;
    if (s > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return s[DATA_W-1:0];
  endfunction

  assign sample_ready = (state == IDLE) & ~wr_en;
  assign result_valid = (state == DONE);
  assign converged    = (cnt == CNT_W'(CONV_COUNT));
  assign y_dec        = ~acc[ACC_W-1];
  assign err_dec      = y_dec ^ t_r;

  always_comb begin
    acc_idx = 2'd0;
    case (state)
      ACC1:    acc_idx = 2'd1;
      ACC2:    acc_idx = 2'd2;
      ACC3:    acc_idx = 2'd3;
      default: acc_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid && sample_ready) state_nxt = ACC0;
      ACC0:    state_nxt = ACC1;
      ACC1:    state_nxt = ACC2;
      ACC2:    state_nxt = ACC3;
      ACC3:    state_nxt = DECIDE;
      DECIDE:  state_nxt = err_dec ? UPDATE : DONE;
      UPDATE:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (!rd_sel[2])          rd_data = w[rd_sel[1:0]];
    else if (rd_sel == 3'd4) rd_data = bias;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      for (int unsigned i = 0; i < 4; i++) w[i] <= '0;
      bias    <= '0;
      acc     <= '0;
      x_r     <= '0;
      t_r     <= 1'b0;
      y_r     <= 1'b0;
      cnt     <= '0;
      y_out   <= 1'b0;
      err_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (!wr_sel[2])          w[wr_sel[1:0]] <= wr_data;
            else if (wr_sel == 3'd4) bias           <= wr_data;
            cnt <= '0;
          end else if (sample_valid) begin
            x_r <= sample_x;
            t_r <= sample_t;
            acc <= {{3{bias[DATA_W-1]}}, bias};
          end
        end
        ACC0, ACC1, ACC2, ACC3: begin
          if (x_r[acc_idx]) acc <= acc + {{3{w[acc_idx][DATA_W-1]}}, w[acc_idx]};
        end
        // A correct decision publishes its result on the way into DONE;
        // an error defers publication until UPDATE so both paths share DONE.
        DECIDE: begin
          y_r <= y_dec;
          if (!err_dec) begin
            y_out   <= y_dec;
            err_out <= 1'b0;
            if (cnt != CNT_W'(CONV_COUNT)) cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          bias <= step_sat(bias, t_r);
          for (int unsigned i = 0; i < 4; i++)
            if (x_r[i]) w[i] <= step_sat(w[i], t_r);
          y_out   <= y_r;
          err_out <= 1'b1;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: expected results are queued at
// sample acceptance and compared by a monitor when result_valid fires.
module tb_perceptron_trainer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sample_x = '0;
  logic       sample_t = 1'b0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       wr_en = 1'b0;
  logic [2:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] rd_sel = '0;
  logic [7:0] rd_data;
  logic       result_valid, y_out, err_out, converged;

  perceptron_trainer #(.DATA_W(8), .LR(1), .CONV_COUNT(16)) dut (
    .clk(clk), .rst(rst),
    .sample_x(sample_x), .sample_t(sample_t), .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .result_valid(result_valid), .y_out(y_out), .err_out(err_out),
    .converged(converged)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic y;
    logic err;
    logic conv;
    int   start;
    int   lat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [3:0] x;
    logic       t;
    logic       y;
    logic       err;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got result_valid=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y_out", y_out, e.y);
        chk("err_out", err_out, e.err);
        chk("converged", converged, e.conv);
        chk("latency", cyc - e.start, e.lat);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] sel, input logic [7:0] exp);
    rd_sel = sel;
    #1;
    chk($sformatf("rd_data[%0d]", sel), rd_data, exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL result_timeout: got %0d results pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] x, input logic t, input logic ey, input logic eerr,
                       input logic econv, input int elat);
    exp_t e;
    @(negedge clk);
    sample_x = x; sample_t = t; sample_valid = 1'b1;
    chk("sample_ready", sample_ready, 1'b1);
    e.y = ey; e.err = eerr; e.conv = econv; e.start = cyc; e.lat = elat;
    q.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
    sample_x = 4'($urandom);
    sample_t = 1'($urandom);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'b0000, 1'b0, 1'b0, 1'b0};  // acc -1
    tbl[1] = '{4'b0001, 1'b1, 1'b1, 1'b0};  // acc  2
    tbl[2] = '{4'b0010, 1'b0, 1'b0, 1'b0};  // acc -3
    tbl[3] = '{4'b0100, 1'b1, 1'b1, 1'b0};  // acc  4
    tbl[4] = '{4'b1000, 1'b0, 1'b0, 1'b0};  // acc -8
    tbl[5] = '{4'b0101, 1'b1, 1'b1, 1'b0};  // acc  7
    tbl[6] = '{4'b1111, 1'b0, 1'b0, 1'b0};  // acc -2
    tbl[7] = '{4'b1100, 1'b0, 1'b0, 1'b0};  // acc -3
    tbl[8] = '{4'b0111, 1'b1, 1'b1, 1'b0};  // acc  5
    tbl[9] = '{4'b1011, 1'b0, 1'b0, 1'b0};  // acc -7

    do_reset();
    @(negedge clk);
    chk("reset_result_valid", result_valid, 1'b0);
    chk("reset_y_out", y_out, 1'b0);
    chk("reset_err_out", err_out, 1'b0);
    chk("reset_converged", converged, 1'b0);
    chk("reset_sample_ready", sample_ready, 1'b1);
    for (int s = 0; s < 8; s++) rd_chk(3'(s), 8'h00);

    // Zero weights: acc=0 -> y=1, correct, no update.
    drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 6);
    for (int s = 0; s < 5; s++) rd_chk(3'(s), 8'h00);

    // Zero weights, t=0 -> error, every register steps down to -1.
    drive(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 7);
    for (int s = 0; s < 5; s++) rd_chk(3'(s), 8'hFF);
    for (int s = 5; s < 8; s++) rd_chk(3'(s), 8'h00);
    repeat (5) @(negedge clk);
    chk("hold_y_out", y_out, 1'b1);
    chk("hold_err_out", err_out, 1'b1);

    // Reset at T+3 abandons the sample.
    do_reset();
    @(negedge clk);
    sample_x = 4'b1111; sample_t = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sample_ready", sample_ready, 1'b1);
    repeat (12) @(negedge clk);
    for (int s = 0; s < 5; s++) rd_chk(3'(s), 8'h00);

    // Saturation: w0 stays at +127, bias moves -128 -> -127.
    wr(3'd0, 8'h7F);
    wr(3'd4, 8'h80);
    drive(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 7);
    rd_chk(3'd0, 8'h7F);
    rd_chk(3'd4, 8'h81);
    rd_chk(3'd1, 8'h00);

    do_reset();
    wr(3'd0, 8'h03);
    wr(3'd1, 8'hFE);
    wr(3'd2, 8'h05);
    wr(3'd3, 8'hF9);
    wr(3'd4, 8'hFF);
    for (int i = 0; i < 10; i++)
      drive(tbl[i].x, tbl[i].t, tbl[i].y, tbl[i].err, 1'b0, 6);

    // acc=2 with t=0 -> error, w0 and bias step down.
    drive(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 7);
    rd_chk(3'd0, 8'h02);
    rd_chk(3'd1, 8'hFE);
    rd_chk(3'd4, 8'hFE);

    // bias=-2, x=0000 t=0 is always correct.
    for (int i = 0; i < 16; i++)
      drive(4'b0000, 1'b0, 1'b0, 1'b0, (i == 15) ? 1'b1 : 1'b0, 6);
    drive(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 7);
    rd_chk(3'd4, 8'hFF);

    // Write wins over a simultaneous sample.
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h11;
    sample_x = 4'b1111; sample_t = 1'b1; sample_valid = 1'b1;
    #1;
    chk("wr_vs_sample_ready", sample_ready, 1'b0);
    @(negedge clk);
    wr_en = 1'b0; sample_valid = 1'b0;
    rd_chk(3'd2, 8'h11);
    repeat (12) @(negedge clk);
    chk("wr_vs_sample_idle", sample_ready, 1'b1);

    // Write during ACC1 is dropped.
    begin
      exp_t e;
      @(negedge clk);
      sample_x = 4'b0000; sample_t = 1'b0; sample_valid = 1'b1;
      e.y = 1'b0; e.err = 1'b0; e.conv = 1'b0; e.start = cyc; e.lat = 6;
      q.push_back(e);
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h55;
      @(negedge clk);
      wr_en = 1'b0;
      drain();
      rd_chk(3'd1, 8'hFE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
